// File: rtl/add_acc_ctrl_if.sv
// ---------------------------------------------------------------------------
// add_acc_ctrl_if
// Bundles every non-clock signal of the adder accumulation sequencer.
// The names carry the sequencer's own direction suffix (_i = into the
// sequencer, _o = out of it).
//   Job request    : start_i, len_i, relu_en_i
//   Operand stream : in_data_i, in_valid_i, in_ready_o
//   Adder side     : add_a_o, add_b_o, add_en_o, skip_neg_en_o, add_sum_i
//   Result stream  : out_data_o, out_valid_o, out_ready_i
//   Status         : busy_o, done_o
// Modports:
//   slave  - the sequencer itself.
//   master - the scheduler/adder environment that drives it.
// ---------------------------------------------------------------------------
interface add_acc_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
);
  logic              start_i;
  logic [CNT_W-1:0]  len_i;
  logic              relu_en_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] add_a_o;
  logic [DATA_W-1:0] add_b_o;
  logic              add_en_o;
  logic              skip_neg_en_o;
  logic [DATA_W-1:0] add_sum_i;
  logic [DATA_W-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  start_i, len_i, relu_en_i, in_data_i, in_valid_i, add_sum_i, out_ready_i,
    output in_ready_o, add_a_o, add_b_o, add_en_o, skip_neg_en_o,
           out_data_o, out_valid_o, busy_o, done_o
  );

  modport master (
    output start_i, len_i, relu_en_i, in_data_i, in_valid_i, add_sum_i, out_ready_i,
    input  in_ready_o, add_a_o, add_b_o, add_en_o, skip_neg_en_o,
           out_data_o, out_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/add_acc_ctrl.sv
// ---------------------------------------------------------------------------
// add_acc_ctrl
// Sequencer for one shared pipelined adder of ADD_LAT cycles latency.
// It accepts a job of len_i operands and accumulates them one add at a time,
// feeding the running sum back through the adder. It finishes with a single
// pass-through flush that can apply skip-negative (ReLU), and then presents
// the result on a valid/ready output.
// Ports:
//   clk_i   - clock, rising edge
//   rst_n_i - synchronous active-low reset
//   bus     - add_acc_ctrl_if.slave (job, operand, adder, result and status)
// ---------------------------------------------------------------------------
module add_acc_ctrl #(
  parameter int DATA_W  = 12,
  parameter int ADD_LAT = 5,
  parameter int CNT_W   = 8
) (
  input logic           clk_i,
  input logic           rst_n_i,
  add_acc_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(ADD_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ADD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_FLUSH,
    S_FWAIT,
    S_OUT
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_rem,       w_rem_nxt;
  logic [WAIT_W-1:0] r_wait,      w_wait_nxt;
  logic [DATA_W-1:0] r_acc,       w_acc_nxt;
  logic              r_relu,      w_relu_nxt;
  logic [DATA_W-1:0] r_add_a,     w_add_a_nxt;
  logic [DATA_W-1:0] r_add_b,     w_add_b_nxt;
  logic              r_add_en,    w_add_en_nxt;
  logic              r_skip,      w_skip_nxt;
  logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_done,      w_done_nxt;

  // Every register, including the adder-facing outputs, loads the value
  // prepared by the next-state logic. Reset discards any job in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_wait      <= '0;
      r_acc       <= '0;
      r_relu      <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_en    <= 1'b0;
      r_skip      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_wait      <= w_wait_nxt;
      r_acc       <= w_acc_nxt;
      r_relu      <= w_relu_nxt;
      r_add_a     <= w_add_a_nxt;
      r_add_b     <= w_add_b_nxt;
      r_add_en    <= w_add_en_nxt;
      r_skip      <= w_skip_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic. The adder operands default to zero,
  // so they are only non-zero for the single cycle after an issue or a
  // flush. The wait counter is loaded with ADD_LAT when an operation goes
  // out. The adder result is sampled on the cycle the counter reaches 0,
  // which is exactly ADD_LAT cycles after the operands were presented.
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_wait_nxt      = r_wait;
    w_acc_nxt       = r_acc;
    w_relu_nxt      = r_relu;
    w_add_a_nxt     = '0;
    w_add_b_nxt     = '0;
    w_add_en_nxt    = 1'b0;
    w_skip_nxt      = 1'b0;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_rem_nxt   = bus.len_i;
          w_relu_nxt  = bus.relu_en_i;
          w_acc_nxt   = '0;
          w_state_nxt = (bus.len_i == '0) ? S_FLUSH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.in_valid_i) begin
          w_add_a_nxt  = r_acc;
          w_add_b_nxt  = bus.in_data_i;
          w_add_en_nxt = 1'b1;
          w_rem_nxt    = r_rem - 1'b1;
          w_wait_nxt   = WAIT_LOAD;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait == '0) begin
          w_acc_nxt   = bus.add_sum_i;
          w_state_nxt = (r_rem != '0) ? S_FETCH : S_FLUSH;
        end else begin
          w_wait_nxt = r_wait - 1'b1;
        end
      end
      S_FLUSH: begin
        // Pass-through: add_en stays low so the low sum bits are kept.
        w_add_a_nxt = r_acc;
        w_skip_nxt  = r_relu;
        w_wait_nxt  = WAIT_LOAD;
        w_state_nxt = S_FWAIT;
      end
      S_FWAIT: begin
        if (r_wait == '0) begin
          w_out_data_nxt  = bus.add_sum_i;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_OUT;
        end else begin
          w_wait_nxt = r_wait - 1'b1;
        end
      end
      S_OUT: begin
        if (bus.out_ready_i) begin
          w_out_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready_o    = (r_state == S_FETCH);
  assign bus.busy_o        = (r_state != S_IDLE);
  assign bus.add_a_o       = r_add_a;
  assign bus.add_b_o       = r_add_b;
  assign bus.add_en_o      = r_add_en;
  assign bus.skip_neg_en_o = r_skip;
  assign bus.out_data_o    = r_out_data;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.done_o        = r_done;

endmodule

// File: tb/tb_add_acc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_acc_ctrl
// Bench for add_acc_ctrl. It holds a behavioural model of the shared adder
// (ADD_LAT-deep pipeline, low-nibble clear on add, ReLU on skip). Each job's
// expected result is computed as a plain fold of its operands.
// ---------------------------------------------------------------------------
module tb_add_acc_ctrl;

  localparam int ADD_LAT = 5;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  add_acc_ctrl_if #(.DATA_W(12), .CNT_W(8)) bus ();

  add_acc_ctrl #(.DATA_W(12), .ADD_LAT(ADD_LAT), .CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_n_i(rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errCnt = 0;
  int chkCnt = 0;
  int cycleCnt = 0;

  // Job description written by the driver and read by the compare process.
  logic [11:0] jobOps [0:255];
  int          jobLen = 0;
  logic        jobRelu = 1'b0;
  logic [11:0] expResult = '0;
  bit          noStall = 1'b0;
  int          startCycle = 0;
  int          jobId = 0;
  bit          monEn = 1'b0;

  // State owned by the compare process.
  int          seenJob = 0;
  int          opIdx = 0;
  logic [11:0] modelAcc = '0;
  int          lastIssue = 0;
  int          readyCycles = 0;
  logic        prevValid = 1'b0;
  logic        hsPrev = 1'b0;
  logic [11:0] prevData = '0;

  logic [11:0] pipe [0:ADD_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One accumulation step: wrap at 12 bits, adder clears the low nibble.
  function automatic logic [11:0] accStep(input logic [11:0] a, input logic [11:0] b);
    return (a + b) & 12'hFF0;
  endfunction

  function automatic logic [11:0] modelResult(input int n, input logic relu);
    logic [11:0] s = '0;
    for (int k = 0; k < n; k++) s = accStep(s, jobOps[k]);
    if (relu && s[11]) s = '0;
    return s;
  endfunction

  function automatic logic [11:0] adderFn(input logic [11:0] a, input logic [11:0] b,
                                          input logic en, input logic skip);
    logic [11:0] s = a + b;
    if (en) s[3:0] = 4'h0;
    if (skip && s[11]) s = '0;
    return s;
  endfunction

  // Adder model: operands seen in cycle c produce a sum visible in cycle c+ADD_LAT.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (!rstN) begin
      for (int k = 0; k < ADD_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= adderFn(bus.add_a_o, bus.add_b_o, bus.add_en_o, bus.skip_neg_en_o);
      for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign bus.add_sum_i = pipe[ADD_LAT-1];

  // Compare process: every cycle, checks issued operands, the flush, the
  // result stream and done against the model of the current job.
  always @(negedge clk) begin
    if (!monEn) begin
      prevValid = 1'b0;
      hsPrev    = 1'b0;
    end else begin
      if (jobId != seenJob) begin
        seenJob     = jobId;
        opIdx       = 0;
        modelAcc    = '0;
        lastIssue   = 0;
        readyCycles = 0;
      end
      if (bus.in_ready_o) begin
        readyCycles++;
        checkOutput("in_ready implies busy", bus.busy_o, 1);
      end
      if (bus.add_en_o) begin
        if (opIdx < jobLen) begin
          checkOutput("add_b operand", bus.add_b_o, jobOps[opIdx]);
          checkOutput("add_a running sum", bus.add_a_o, modelAcc);
          checkOutput("skip low on add", bus.skip_neg_en_o, 0);
          if (noStall && opIdx > 0)
            checkOutput("add_en spacing", cycleCnt - lastIssue, ADD_LAT + 2);
          lastIssue = cycleCnt;
          modelAcc  = accStep(modelAcc, jobOps[opIdx]);
          opIdx++;
        end else begin
          checkOutput("add_en count", opIdx + 1, jobLen);
        end
      end else if (bus.add_a_o != 0 || bus.add_b_o != 0 || bus.skip_neg_en_o) begin
        checkOutput("flush add_a", bus.add_a_o, modelAcc);
        checkOutput("flush add_b", bus.add_b_o, 0);
        checkOutput("flush skip", bus.skip_neg_en_o, jobRelu);
        checkOutput("flush after all ops", opIdx, jobLen);
      end
      checkOutput("done pulse", bus.done_o, hsPrev);
      if (hsPrev) checkOutput("out_valid drop", bus.out_valid_o, 0);
      else if (prevValid) checkOutput("out_valid held", bus.out_valid_o, 1);
      if (bus.out_valid_o) begin
        if (!prevValid) begin
          checkOutput("result vs model", bus.out_data_o, expResult);
          if (noStall) checkOutput("start-to-valid latency", cycleCnt - startCycle,
                                   jobLen * (ADD_LAT + 2) + ADD_LAT + 2);
        end else if (!hsPrev) begin
          checkOutput("out_data stable", bus.out_data_o, prevData);
        end
      end
      prevValid = bus.out_valid_o;
      prevData  = bus.out_data_o;
      hsPrev    = bus.out_valid_o && bus.out_ready_i;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " add_a"}, bus.add_a_o, 0);
    checkOutput({tag, " add_b"}, bus.add_b_o, 0);
    checkOutput({tag, " add_en"}, bus.add_en_o, 0);
    checkOutput({tag, " skip"}, bus.skip_neg_en_o, 0);
    checkOutput({tag, " out_data"}, bus.out_data_o, 0);
    checkOutput({tag, " out_valid"}, bus.out_valid_o, 0);
    checkOutput({tag, " in_ready"}, bus.in_ready_o, 0);
    checkOutput({tag, " busy"}, bus.busy_o, 0);
    checkOutput({tag, " done"}, bus.done_o, 0);
  endtask

  task automatic setOps(input int n, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c, input logic [11:0] d);
    jobOps[0] = a; jobOps[1] = b; jobOps[2] = c; jobOps[3] = d;
    for (int k = 4; k < 256; k++) jobOps[k] = '0;
    if (n > 4) $display("[TB] setOps only fills 4 operands");
  endtask

  // Runs one job. It returns at the negedge of the done cycle, so the next
  // call's start coincides with done.
  task automatic applyStimulus(input string name, input int len, input logic relu,
                               input bit gaps, input int holdCycles, input bit pulseStart,
                               input logic [11:0] expLit);
    int k = 0;
    int guard = 0;
    bit hs;
    bit seen = 1'b0;
    logic [11:0] got = '0;
    jobLen    = len;
    jobRelu   = relu;
    expResult = modelResult(len, relu);
    noStall   = !gaps;
    jobId++;
    bus.out_ready_i = (holdCycles == 0);
    bus.start_i     = 1'b1;
    bus.len_i       = 8'(len);
    bus.relu_en_i   = relu;
    @(posedge clk); #1;
    startCycle  = cycleCnt;
    bus.start_i = 1'b0;
    while (k < len && guard < 20 * len + 50) begin
      bus.in_data_i  = jobOps[k];
      bus.in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      hs = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    bus.in_valid_i = 1'b0;
    if (k != len) checkOutput({name, " operand accept timeout"}, k, len);
    for (int g = 0; g < 8 * len + 40 && !seen; g++) begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        seen = 1'b1;
        got  = bus.out_data_o;
      end
    end
    if (!seen) checkOutput({name, " out_valid timeout"}, bus.out_valid_o, 1);
    if (holdCycles > 0) begin
      for (int d = 0; d < holdCycles; d++) begin
        @(posedge clk); #1;
        bus.start_i = pulseStart && (d % 3 == 1);
        bus.len_i   = 8'd5;
      end
      bus.start_i     = 1'b0;
      bus.out_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    checkOutput({name, " result literal"}, got, expLit);
    checkOutput({name, " done after handshake"}, bus.done_o, 1);
    checkOutput({name, " idle after handshake"}, bus.busy_o, 0);
    if (noStall) checkOutput({name, " in_ready cycles"}, readyCycles, len);
    else checkOutput({name, " in_ready cycles >= len"}, readyCycles >= len, 1);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.len_i       = '0;
    bus.relu_en_i   = 1'b0;
    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    @(posedge clk); #1;
    monEn = 1'b1;
    @(negedge clk);

    setOps(3, 12'h010, 12'h020, 12'h030, 12'h000);
    applyStimulus("three ops", 3, 1'b0, 1'b0, 0, 1'b0, 12'h060);
    setOps(2, 12'h010, 12'hFC0, 12'h000, 12'h000);
    applyStimulus("relu negative", 2, 1'b1, 1'b0, 0, 1'b0, 12'h000);
    applyStimulus("no relu negative", 2, 1'b0, 1'b0, 2, 1'b0, 12'hFD0);
    applyStimulus("len zero", 0, 1'b1, 1'b0, 0, 1'b0, 12'h000);
    setOps(2, 12'h800, 12'h800, 12'h000, 12'h000);
    applyStimulus("wrap", 2, 1'b0, 1'b0, 0, 1'b0, 12'h000);
    setOps(2, 12'h00F, 12'h001, 12'h000, 12'h000);
    applyStimulus("low nibble clear", 2, 1'b0, 1'b0, 0, 1'b0, 12'h000);
    setOps(2, 12'h123, 12'h045, 12'h000, 12'h000);
    applyStimulus("hold output", 2, 1'b0, 1'b0, 10, 1'b1, 12'h160);
    setOps(4, 12'h111, 12'h222, 12'h333, 12'h0A5);
    applyStimulus("valid gaps", 4, 1'b1, 1'b1, 0, 1'b0, 12'h700);
    applyStimulus("no gaps same sum", 4, 1'b1, 1'b0, 1, 1'b0, 12'h700);

    // Reset while the adder operation is in flight.
    monEn         = 1'b0;
    bus.start_i   = 1'b1;
    bus.len_i     = 8'd3;
    bus.relu_en_i = 1'b0;
    @(posedge clk); #1;
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 12'h100;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("busy in WAIT", bus.busy_o, 1);
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    checkAllZero("mid-job reset");
    monEn = 1'b1;
    @(negedge clk);
    setOps(3, 12'h100, 12'h200, 12'h300, 12'h000);
    applyStimulus("after reset", 3, 1'b1, 1'b0, 0, 1'b0, 12'h600);

    for (int k = 0; k < 256; k++) jobOps[k] = 12'h010;
    applyStimulus("max length", 255, 1'b0, 1'b0, 0, 1'b0, 12'hFF0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
